// File: rtl/restoring_divider8_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : restoring_divider8_pkg
//  Description : Shared constants and FSM state type for the 16/8 restoring
//                divider (top: restoring_divider8, datapath step: div_step).
//  Contents    : DW/VW widths, ITER iteration count, counter width, the
//                quotient returned on divide-by-zero, and state_t.
//  Revision    : 1.0 - initial release
// ============================================================================
package restoring_divider8_pkg;

    localparam int DW   = 16;               // dividend / quotient width
    localparam int VW   = 8;                // divisor / remainder width
    localparam int ITER = 16;               // one iteration per quotient bit
    localparam int CW   = $clog2(ITER + 1); // counter must hold ITER itself

    localparam logic [DW-1:0] c_dbz_quotient = 16'hFFFF;
    localparam logic [CW-1:0] c_iter_load    = CW'(ITER);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/div_step.sv
`default_nettype none
// ============================================================================
//  Module      : div_step
//  Description : One combinational restoring-division iteration. Shifts the
//                next dividend bit into the 9-bit partial remainder, trial-
//                subtracts the divisor and either keeps the difference
//                (quotient bit 1) or restores the shifted value (bit 0).
//  Ports       : rem_in   [8:0] partial remainder before this step
//                dvd_msb        dividend bit shifted in this step
//                divisor  [7:0] divisor
//                rem_out  [8:0] partial remainder after this step
//                q_bit          quotient bit produced by this step
//  Revision    : 1.0 - initial release
// ============================================================================
module div_step
    import restoring_divider8_pkg::*;
(
    input  logic [VW:0]   rem_in,
    input  logic          dvd_msb,
    input  logic [VW-1:0] divisor,
    output logic [VW:0]   rem_out,
    output logic          q_bit
);

    // One extra bit above the 9-bit partial remainder holds the sign of the
    // trial difference. The shifted value never exceeds 2*255+1, so a 10-bit
    // two's complement difference cannot wrap.
    logic [VW+1:0] w_shifted;
    logic [VW+1:0] w_diff;

    assign w_shifted = {rem_in, dvd_msb};
    assign w_diff    = w_shifted - {2'b00, divisor};
    assign q_bit     = ~w_diff[VW+1];
    assign rem_out   = q_bit ? w_diff[VW:0] : w_shifted[VW:0];

endmodule
`default_nettype wire

// File: rtl/restoring_divider8.sv
`default_nettype none
// ============================================================================
//  Module      : restoring_divider8
//  Description : Sequential 16-bit / 8-bit unsigned restoring divider, one
//                quotient bit per clock. A request is accepted in IDLE,
//                takes 16 CALC cycles and presents a one-cycle done pulse in
//                DONE. A zero divisor skips CALC and reports div_by_zero.
//  Ports       : clk, rst_n (async, active-low)
//                start, dividend[15:0], divisor[7:0]   request
//                busy, done, quotient[15:0], remainder[7:0], div_by_zero
//  Revision    : 1.0 - initial release
// ============================================================================
module restoring_divider8 #(
    parameter int DW = 16,
    parameter int VW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [DW-1:0] dividend,
    input  logic [VW-1:0] divisor,
    output logic          busy,
    output logic          done,
    output logic [DW-1:0] quotient,
    output logic [VW-1:0] remainder,
    output logic          div_by_zero
);

    import restoring_divider8_pkg::*;

    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic [VW:0]   r_rem;      // 9-bit partial remainder
    logic [DW-1:0] r_dvd;      // dividend shifts out the top, quotient fills the bottom
    logic [VW-1:0] r_divisor;

    logic [VW:0]   w_rem_next;
    logic          w_q_bit;

    div_step u_div_step (
        .rem_in  (r_rem),
        .dvd_msb (r_dvd[DW-1]),
        .divisor (r_divisor),
        .rem_out (w_rem_next),
        .q_bit   (w_q_bit)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_rem       <= '0;
            r_dvd       <= '0;
            r_divisor   <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        busy      <= 1'b1;
                        r_divisor <= divisor;
                        if (divisor == '0) begin
                            // No iterations: results are defined directly.
                            quotient    <= c_dbz_quotient;
                            remainder   <= dividend[VW-1:0];
                            div_by_zero <= 1'b1;
                            done        <= 1'b1;
                            r_state     <= DONE;
                        end else begin
                            r_dvd       <= dividend;
                            r_rem       <= '0;
                            r_cnt       <= c_iter_load;
                            div_by_zero <= 1'b0;
                            r_state     <= CALC;
                        end
                    end
                end
                CALC: begin
                    r_rem <= w_rem_next;
                    r_dvd <= {r_dvd[DW-2:0], w_q_bit};
                    r_cnt <= r_cnt - 1'b1;
                    // Last iteration: publish the final step directly so the
                    // results appear together with done.
                    if (r_cnt == CW'(1)) begin
                        quotient  <= {r_dvd[DW-2:0], w_q_bit};
                        remainder <= w_rem_next[VW-1:0];
                        done      <= 1'b1;
                        r_state   <= DONE;
                    end
                end
                DONE: begin
                    busy    <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_restoring_divider8.sv
`default_nettype none
// ============================================================================
//  Module      : tb_restoring_divider8
//  Description : Self-checking bench for restoring_divider8 using directed
//                vectors plus a back-to-back random sweep checked against
//                integer division.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_restoring_divider8;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] dividend;
    logic [7:0]  divisor;
    logic        busy;
    logic        done;
    logic [15:0] quotient;
    logic [7:0]  remainder;
    logic        div_by_zero;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;
    int start_cyc;
    int done_cyc;
    int prev_done_cyc;

    restoring_divider8 #(.DW(16), .VW(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    // Issue one request and check its results. poke_at: iteration after which
    // a one-cycle start with other operands is driven (0 = none). abort_at:
    // iteration after which reset is pulsed and the division abandoned.
    task automatic run_div(input string tag, input logic [15:0] a, input logic [7:0] b,
                           input int poke_at, input int abort_at);
        logic [15:0] eq;
        logic [7:0]  er;
        logic        ez;
        int          elat;
        int          n;
        if (b == 8'd0) begin
            eq = 16'hFFFF; er = a[7:0]; ez = 1'b1; elat = 0;
        end else begin
            eq = a / b; er = 8'(a % b); ez = 1'b0; elat = 16;
        end
        n = 0;
        while (busy && n < 40) begin
            @(posedge clk); #1; n++;
        end
        check_val({tag, ":idle"}, {31'd0, busy}, 32'd0);
        @(negedge clk);
        start = 1'b1; dividend = a; divisor = b;
        @(posedge clk); #1;
        start_cyc = cyc;
        start = 1'b0;
        // Scramble operand inputs so a late recapture would corrupt results.
        dividend = 16'($urandom); divisor = 8'($urandom);
        check_val({tag, ":busy"}, {31'd0, busy}, 32'd1);
        n = 0;
        while (!done && n < 40) begin
            @(posedge clk); #1; n++;
            if (poke_at != 0 && n == poke_at) begin
                start = 1'b1; dividend = 16'd9; divisor = 8'd2;
            end
            if (poke_at != 0 && n == poke_at + 1) start = 1'b0;
            if (abort_at != 0 && n == abort_at) begin
                rst_n = 1'b0;
                #1;
                check_val({tag, ":rst_busy"}, {31'd0, busy}, 32'd0);
                check_val({tag, ":rst_done"}, {31'd0, done}, 32'd0);
                check_val({tag, ":rst_q"}, {16'd0, quotient}, 32'd0);
                check_val({tag, ":rst_r"}, {24'd0, remainder}, 32'd0);
                check_val({tag, ":rst_dbz"}, {31'd0, div_by_zero}, 32'd0);
                @(negedge clk); rst_n = 1'b1;
                for (int i = 0; i < 20; i++) begin
                    @(posedge clk); #1;
                    check_val({tag, ":no_done"}, {31'd0, done}, 32'd0);
                end
                return;
            end
        end
        done_cyc = cyc;
        check_val({tag, ":lat"}, 32'(n), 32'(elat));
        check_val({tag, ":q"}, {16'd0, quotient}, {16'd0, eq});
        check_val({tag, ":r"}, {24'd0, remainder}, {24'd0, er});
        check_val({tag, ":dbz"}, {31'd0, div_by_zero}, {31'd0, ez});
        @(posedge clk); #1;
        check_val({tag, ":pulse"}, {31'd0, done}, 32'd0);
        check_val({tag, ":hold_q"}, {16'd0, quotient}, {16'd0, eq});
        check_val({tag, ":idle2"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        logic [15:0] ra;
        logic [7:0]  rb;
        rst_n = 1'b0; start = 1'b1; dividend = 16'd1000; divisor = 8'd7;
        repeat (3) @(posedge clk);
        #1;
        check_val("reset:busy", {31'd0, busy}, 32'd0);
        check_val("reset:done", {31'd0, done}, 32'd0);
        check_val("reset:q", {16'd0, quotient}, 32'd0);
        check_val("reset:r", {24'd0, remainder}, 32'd0);
        check_val("reset:dbz", {31'd0, div_by_zero}, 32'd0);
        @(negedge clk); start = 1'b0; rst_n = 1'b1;
        @(posedge clk); #1;
        check_val("post_reset:busy", {31'd0, busy}, 32'd0);

        run_div("d1000_7", 16'd1000, 8'd7, 0, 0);          // 142 r 6
        run_div("dffff_1", 16'hFFFF, 8'd1, 0, 0);          // 65535 r 0
        run_div("dffff_ff", 16'hFFFF, 8'hFF, 0, 0);        // 257 r 0
        run_div("d1234_0", 16'h1234, 8'd0, 0, 0);          // FFFF r 34, dbz
        run_div("d100_10", 16'd100, 8'd10, 0, 0);          // 10 r 0, dbz cleared
        run_div("d500_3_poke", 16'd500, 8'd3, 5, 0);       // 166 r 2, poke ignored
        run_div("d4000_9_abort", 16'd4000, 8'd9, 0, 8);
        run_div("d4000_9", 16'd4000, 8'd9, 0, 0);          // 444 r 4
        run_div("d0_5", 16'd0, 8'd5, 0, 0);                // 0 r 0
        run_div("d254_255", 16'd254, 8'd255, 0, 0);        // 0 r 254

        for (int i = 0; i < 120; i++) begin
            ra = 16'($urandom);
            rb = (i % 15 == 0) ? 8'd0 : 8'($urandom);
            prev_done_cyc = done_cyc;
            run_div("rand", ra, rb, 0, 0);
            check_val("rand:b2b", 32'(start_cyc - prev_done_cyc), 32'd2);
            if (rb != 8'd0) begin
                check_val("rand:ident", 32'(quotient) * 32'(rb) + 32'(remainder), 32'(ra));
                check_val("rand:rlt", {31'd0, remainder < rb}, 32'd1);
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
